// File: rtl/ping_scan.sv
// ping_scan: fires each enabled ultrasonic channel in turn, converts echo width to cm/in, banks results.
// Result latency is trigger + echo delay + echo width + 2 sync cycles; there is no backpressure, and go is ignored while busy.
module ping_scan #(
  parameter int NCH        = 4,
  parameter int RES_W      = 8,
  parameter int TRIG_CYC   = 2,
  parameter int HOLD_CYC   = 300,
  parameter int CYC_PER_CM = 23,
  parameter int CYC_PER_IN = 58,
  parameter int ECHO_MAX   = 8000,
  parameter int GAP_CYC    = 4000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             cont,
  input  logic             inches,
  input  logic [NCH-1:0]   ch_mask,
  input  logic [NCH-1:0]   pulsein,
  output logic [NCH-1:0]   pulseout,
  output logic [NCH-1:0]   pulseen,
  output logic             busy,
  output logic [2:0]       chan,
  output logic             convdone,
  output logic [RES_W-1:0] result,
  output logic             tmo,
  input  logic [2:0]       rd_sel,
  output logic [RES_W-1:0] rd_data
);
  localparam int CMAX = (HOLD_CYC > GAP_CYC) ? ((HOLD_CYC > TRIG_CYC) ? HOLD_CYC : TRIG_CYC)
                                             : ((GAP_CYC > TRIG_CYC) ? GAP_CYC : TRIG_CYC);
  localparam int CW   = $clog2(CMAX + 1);
  localparam int EW   = $clog2(ECHO_MAX + 1);
  localparam int PMAX = (CYC_PER_IN > CYC_PER_CM) ? CYC_PER_IN : CYC_PER_CM;
  localparam int PW   = $clog2(PMAX + 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAITR, ECHO, GAP} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [EW-1:0]    ecnt;
  logic [PW-1:0]    pre;
  logic [RES_W-1:0] acc;
  logic             unit_in;
  logic [NCH-1:0]   mask_q;
  logic [NCH-1:0]   sync1, sync2, sync3;
  logic [RES_W-1:0] bank [8];

  logic             echo_now, echo_prev, rise;
  logic             nxt_found;
  logic [2:0]       nxt_idx;
  logic             launch;
  logic [2:0]       launch_idx;
  logic             do_write, wr_tmo;
  logic [RES_W-1:0] wr_val;
  logic [PW-1:0]    div_last;

  function automatic logic [2:0] lowest(input logic [NCH-1:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  always_comb begin
    echo_now  = 1'b0;
    echo_prev = 1'b0;
    nxt_found = 1'b0;
    nxt_idx   = chan;
    for (int i = 0; i < NCH; i++) begin
      if (i == int'(chan)) begin
        echo_now  = sync2[i];
        echo_prev = sync3[i];
      end
      if (!nxt_found && i > int'(chan) && mask_q[i]) begin
        nxt_found = 1'b1;
        nxt_idx   = 3'(i);
      end
    end
  end

  assign rise     = echo_now & ~echo_prev;
  assign div_last = unit_in ? PW'(CYC_PER_IN - 1) : PW'(CYC_PER_CM - 1);
  // Bank is written the cycle after the strobe, so a same-cycle read still returns the old entry.
  assign rd_data  = bank[rd_sel];

  always_comb begin
    launch     = 1'b0;
    launch_idx = chan;
    do_write   = 1'b0;
    wr_val     = acc;
    wr_tmo     = 1'b0;
    case (state)
      IDLE: if (go && |ch_mask) begin
        launch     = 1'b1;
        launch_idx = lowest(ch_mask);
      end
      WAITR: if (!rise && cnt == CW'(HOLD_CYC - 1)) begin
        do_write = 1'b1;
        wr_val   = '1;
        wr_tmo   = 1'b1;
      end
      ECHO: if (!echo_now) begin
        do_write = 1'b1;
      end else if (ecnt == EW'(ECHO_MAX)) begin
        do_write = 1'b1;
        wr_val   = '1;
        wr_tmo   = 1'b1;
      end
      GAP: if (cnt == CW'(GAP_CYC - 1)) begin
        if (nxt_found) begin
          launch     = 1'b1;
          launch_idx = nxt_idx;
        end else if (cont) begin
          launch     = 1'b1;
          launch_idx = lowest(mask_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      ecnt     <= '0;
      pre      <= '0;
      acc      <= '0;
      unit_in  <= 1'b0;
      mask_q   <= '0;
      sync1    <= '0;
      sync2    <= '0;
      sync3    <= '0;
      pulseout <= '0;
      pulseen  <= '0;
      busy     <= 1'b0;
      chan     <= '0;
      convdone <= 1'b0;
      result   <= '0;
      tmo      <= 1'b0;
      for (int i = 0; i < 8; i++) bank[i] <= '0;
    end else begin
      sync1    <= pulsein;
      sync2    <= sync1;
      sync3    <= sync2;
      convdone <= do_write;
      if (convdone) bank[chan] <= result;
      case (state)
        IDLE: if (launch) begin
          mask_q <= ch_mask;
          busy   <= 1'b1;
        end
        TRIG: if (cnt == CW'(TRIG_CYC - 1)) begin
          pulseout <= '0;
          pulseen  <= '0;
          cnt      <= '0;
          state    <= WAITR;
        end else begin
          cnt <= cnt + 1'b1;
        end
        WAITR: if (rise) begin
          // The rise cycle itself is the first cycle of echo width.
          state <= ECHO;
          ecnt  <= EW'(1);
          pre   <= PW'(1);
          acc   <= '0;
        end else if (!do_write) begin
          cnt <= cnt + 1'b1;
        end
        ECHO: if (!do_write) begin
          ecnt <= ecnt + 1'b1;
          if (pre == div_last) begin
            pre <= '0;
            if (acc != '1) acc <= acc + 1'b1;
          end else begin
            pre <= pre + 1'b1;
          end
        end
        GAP: if (cnt == CW'(GAP_CYC - 1)) begin
          if (!launch) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (do_write) begin
        result <= wr_val;
        tmo    <= wr_tmo;
        cnt    <= '0;
        state  <= GAP;
      end
      if (launch) begin
        chan     <= launch_idx;
        unit_in  <= inches;
        cnt      <= '0;
        state    <= TRIG;
        pulseen  <= NCH'(1) << launch_idx;
        pulseout <= NCH'(1) << launch_idx;
      end
    end
  end
endmodule

// File: tb/tb_ping_scan.sv
// Directed bench for ping_scan: reset, cm/inch conversion, saturation, timeouts, scan order, abuse cases.
module tb_ping_scan;
  localparam int NCH      = 4;
  localparam int RES_W    = 8;
  localparam int TRIG_CYC = 2;
  localparam int HOLD_CYC = 300;
  localparam int ECHO_MAX = 20000;
  localparam int GAP_CYC  = 100;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             go = 1'b0;
  logic             cont = 1'b0;
  logic             inches = 1'b0;
  logic [NCH-1:0]   ch_mask = '0;
  logic [NCH-1:0]   pulsein = '0;
  logic [NCH-1:0]   pulseout, pulseen;
  logic             busy, convdone, tmo;
  logic [2:0]       chan;
  logic [RES_W-1:0] result, rd_data;
  logic [2:0]       rd_sel = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_trig3  = 0;

  ping_scan #(
    .NCH(NCH), .RES_W(RES_W), .TRIG_CYC(TRIG_CYC), .HOLD_CYC(HOLD_CYC),
    .CYC_PER_CM(23), .CYC_PER_IN(58), .ECHO_MAX(ECHO_MAX), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .cont(cont), .inches(inches),
    .ch_mask(ch_mask), .pulsein(pulsein), .pulseout(pulseout), .pulseen(pulseen),
    .busy(busy), .chan(chan), .convdone(convdone), .result(result), .tmo(tmo),
    .rd_sel(rd_sel), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (convdone === 1'b1) n_done++;
    if (pulseen[3] === 1'b1) n_trig3++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_done(input int lim, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 1; i <= lim; i++) begin
      tick();
      if (convdone === 1'b1) begin
        ok = 1'b1;
        n  = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Waits for the trigger on channel ch, then drives an echo; width < 0 leaves the pin high.
  task automatic echo_pulse(input int ch, input int dly, input int width, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      tick();
      if (pulseen[ch] === 1'b1) ok = 1'b1;
    end
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
        tick();
        if (pulseen[ch] === 1'b0) ok = 1'b1;
      end
    end
    if (ok) begin
      repeat (dly) tick();
      pulsein[ch] = 1'b1;
      if (width >= 0) begin
        repeat (width) tick();
        pulsein[ch] = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    pulsein = '1;
    ch_mask = '1;
    reset   = 1'b0;
    repeat (3) tick();
    n_checks++; if (pulseen !== 4'b0) begin n_fail++; $display("FAIL reset_pulseen: got %b want 0000", pulseen); end
    n_checks++; if (pulseout !== 4'b0) begin n_fail++; $display("FAIL reset_pulseout: got %b want 0000", pulseout); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (convdone !== 1'b0 || tmo !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got convdone=%b tmo=%b want 0 0", convdone, tmo); end
    n_checks++; if (result !== 8'd0 || chan !== 3'd0) begin n_fail++; $display("FAIL reset_result: got result=%0d chan=%0d want 0 0", result, chan); end
    for (int i = 0; i < 8; i++) begin
      rd_sel = 3'(i);
      #1;
      n_checks++; if (rd_data !== 8'd0) begin n_fail++; $display("FAIL reset_bank%0d: got %0d want 0", i, rd_data); end
    end
    reset   = 1'b1;
    pulsein = '0;
    ch_mask = '0;
    repeat (5) tick();
  endtask

  task automatic test_single_cm();
    bit ok;
    int n, d0, cnt;
    ch_mask = 4'b0001;
    inches  = 1'b0;
    cont    = 1'b0;
    d0      = n_done;
    rd_sel  = 3'd0;
    pulse_go();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cm_busy_rise: got %b want 1", busy); end
    n_checks++; if (pulseen !== 4'b0001) begin n_fail++; $display("FAIL cm_pulseen: got %b want 0001", pulseen); end
    cnt = 0;
    while (pulseout[0] === 1'b1 && cnt < 10) begin
      cnt++;
      tick();
    end
    n_checks++; if (cnt != TRIG_CYC) begin n_fail++; $display("FAIL cm_trig_width: got %0d want %0d", cnt, TRIG_CYC); end
    n_checks++; if (pulseen !== 4'b0) begin n_fail++; $display("FAIL cm_release: got %b want 0000", pulseen); end
    repeat (48) tick();
    pulsein[0] = 1'b1;
    repeat (230) tick();
    pulsein[0] = 1'b0;
    wait_done(40, ok, n);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL cm_done: got none want convdone"); end
    n_checks++; if (result !== 8'd10 || tmo !== 1'b0) begin n_fail++; $display("FAIL cm_result: got %0d tmo=%b want 10 tmo=0", result, tmo); end
    n_checks++; if (rd_data !== 8'd0) begin n_fail++; $display("FAIL cm_rd_same_cycle: got %0d want 0", rd_data); end
    tick();
    n_checks++; if (rd_data !== 8'd10) begin n_fail++; $display("FAIL cm_bank0: got %0d want 10", rd_data); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cm_busy_gap: got %b want 1", busy); end
    wait_idle(GAP_CYC + 20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL cm_busy_fall: got busy=%b want 0", busy); end
    n_checks++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL cm_done_count: got %0d want 1", n_done - d0); end
    // One cycle short of the tenth centimetre.
    pulse_go();
    echo_pulse(0, 30, 229, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL cm229_trig: got no trigger want trigger"); end
    wait_done(40, ok, n);
    n_checks++; if (!ok || result !== 8'd9) begin n_fail++; $display("FAIL cm229_result: got %0d want 9", result); end
    wait_idle(GAP_CYC + 20, ok);
  endtask

  task automatic test_inches_sat();
    bit ok;
    int n;
    ch_mask = 4'b0010;
    inches  = 1'b1;
    pulse_go();
    echo_pulse(1, 20, 116, ok);
    wait_done(40, ok, n);
    n_checks++; if (!ok || result !== 8'd2 || chan !== 3'd1) begin n_fail++; $display("FAIL in_result: got %0d chan=%0d want 2 chan=1", result, chan); end
    wait_idle(GAP_CYC + 20, ok);
    pulse_go();
    echo_pulse(1, 20, 58 * 300, ok);
    wait_done(40, ok, n);
    n_checks++; if (!ok || result !== 8'd255 || tmo !== 1'b0) begin n_fail++; $display("FAIL sat_result: got %0d tmo=%b want 255 tmo=0", result, tmo); end
    tick();
    rd_sel = 3'd1;
    #1;
    n_checks++; if (rd_data !== 8'd255) begin n_fail++; $display("FAIL sat_bank1: got %0d want 255", rd_data); end
    rd_sel = 3'd0;
    #1;
    n_checks++; if (rd_data !== 8'd9) begin n_fail++; $display("FAIL sat_bank0_kept: got %0d want 9", rd_data); end
    wait_idle(GAP_CYC + 20, ok);
    inches = 1'b0;
  endtask

  task automatic test_timeouts();
    bit ok;
    int n;
    ch_mask = 4'b0100;
    pulse_go();
    wait_done(400, ok, n);
    n_checks++; if (!ok || n < TRIG_CYC + HOLD_CYC || n > TRIG_CYC + HOLD_CYC + 3) begin n_fail++; $display("FAIL hold_latency: got %0d want %0d..%0d", n, TRIG_CYC + HOLD_CYC, TRIG_CYC + HOLD_CYC + 3); end
    n_checks++; if (tmo !== 1'b1 || result !== 8'd255 || chan !== 3'd2) begin n_fail++; $display("FAIL hold_tmo: got tmo=%b result=%0d chan=%0d want 1 255 2", tmo, result, chan); end
    tick();
    rd_sel = 3'd2;
    #1;
    n_checks++; if (rd_data !== 8'd255) begin n_fail++; $display("FAIL hold_bank2: got %0d want 255", rd_data); end
    wait_idle(GAP_CYC + 20, ok);
    ch_mask = 4'b0001;
    pulse_go();
    echo_pulse(0, 10, -1, ok);
    wait_done(ECHO_MAX + 50, ok, n);
    n_checks++; if (!ok || n < ECHO_MAX || n > ECHO_MAX + 5) begin n_fail++; $display("FAIL echo_latency: got %0d want %0d..%0d", n, ECHO_MAX, ECHO_MAX + 5); end
    n_checks++; if (tmo !== 1'b1 || result !== 8'd255) begin n_fail++; $display("FAIL echo_tmo: got tmo=%b result=%0d want 1 255", tmo, result); end
    pulsein = '0;
    wait_idle(GAP_CYC + 20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL echo_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_multi_cont();
    bit ok;
    int n, d0, ch;
    int exp_ch[4]  = '{1, 3, 1, 3};
    int exp_res[4] = '{2, 3, 2, 3};
    ch_mask = 4'b1010;
    cont    = 1'b1;
    d0      = n_done;
    pulse_go();
    ch_mask = 4'b0001;
    for (int s = 0; s < 4; s++) begin
      ch = exp_ch[s];
      echo_pulse(ch, 10, (ch == 1) ? 46 : 69, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL multi_trig%0d: got no trigger on ch%0d want trigger", s, ch); end
      if (s == 3) cont = 1'b0;
      wait_done(40, ok, n);
      n_checks++; if (!ok || int'(chan) != ch || int'(result) != exp_res[s]) begin n_fail++; $display("FAIL multi_step%0d: got chan=%0d result=%0d want %0d %0d", s, chan, result, ch, exp_res[s]); end
    end
    wait_idle(GAP_CYC + 20, ok);
    n_checks++; if (!ok || pulseen !== 4'b0) begin n_fail++; $display("FAIL multi_stop: got busy=%b pulseen=%b want 0 0000", busy, pulseen); end
    n_checks++; if (n_done - d0 != 4) begin n_fail++; $display("FAIL multi_count: got %0d want 4", n_done - d0); end
  endtask

  task automatic test_abuse();
    bit ok;
    int n, d0, t0;
    ch_mask = 4'b0000;
    pulse_go();
    repeat (5) tick();
    n_checks++; if (busy !== 1'b0 || pulseen !== 4'b0) begin n_fail++; $display("FAIL mask0_go: got busy=%b pulseen=%b want 0 0000", busy, pulseen); end
    ch_mask = 4'b0001;
    d0      = n_done;
    t0      = n_trig3;
    pulse_go();
    tick();
    ch_mask = 4'b1000;
    pulse_go();
    repeat (10) tick();
    pulsein[0] = 1'b1;
    repeat (92) tick();
    pulsein[0] = 1'b0;
    wait_done(40, ok, n);
    n_checks++; if (!ok || result !== 8'd4 || chan !== 3'd0) begin n_fail++; $display("FAIL busy_go_result: got %0d chan=%0d want 4 chan=0", result, chan); end
    wait_idle(GAP_CYC + 20, ok);
    n_checks++; if (!ok || n_done - d0 != 1 || n_trig3 != t0) begin n_fail++; $display("FAIL busy_go_ignored: got done=%0d trig3=%0d want 1 0", n_done - d0, n_trig3 - t0); end
    ch_mask = 4'b0001;
    pulse_go();
    reset = 1'b0;
    #1;
    n_checks++; if (pulseen !== 4'b0 || pulseout !== 4'b0) begin n_fail++; $display("FAIL rst_trig_pins: got en=%b out=%b want 0000 0000", pulseen, pulseout); end
    tick();
    reset = 1'b1;
    tick();
    d0 = n_done;
    pulse_go();
    repeat (10) tick();
    pulsein[0] = 1'b1;
    repeat (40) tick();
    reset = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || pulseen !== 4'b0 || convdone !== 1'b0) begin n_fail++; $display("FAIL rst_echo_state: got busy=%b en=%b done=%b want 0 0000 0", busy, pulseen, convdone); end
    pulsein = '0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (400) tick();
    n_checks++; if (n_done != d0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_echo_strobe: got strobes=%0d busy=%b want 0 0", n_done - d0, busy); end
    rd_sel = 3'd0;
    #1;
    n_checks++; if (rd_data !== 8'd0) begin n_fail++; $display("FAIL rst_bank_clear: got %0d want 0", rd_data); end
  endtask

  initial begin
    test_reset();
    test_single_cm();
    test_inches_sat();
    test_timeouts();
    test_multi_cont();
    test_abuse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
